// File: rtl/shade_pkg.sv
// shade_pkg: shared types and constants for the flat-shader dispatch block.
package shade_pkg;
    localparam int COLOR_W  = 4;
    localparam int DEF_ID_W = 8;
    typedef enum logic [2:0] {INIT, IDLE, LAUNCH, ARM, BUSY} disp_state_t;
    typedef struct packed {
        logic [31:0] x, y, z;
    } vec3_t;
    typedef struct packed {
        vec3_t p1, p2, p3;
        logic [DEF_ID_W-1:0] id;
    } tri_entry_t;
endpackage

// File: rtl/shade_dispatch_if.sv
// shade_dispatch_if: triangle input stream, shader launch port and result stream.
interface shade_dispatch_if import shade_pkg::*; #(parameter int ID_W = DEF_ID_W);
    logic                in_valid, in_ready;
    vec3_t               in_p1, in_p2, in_p3;
    logic [ID_W-1:0]     in_id;
    logic                sh_start, sh_sreset;
    vec3_t               sh_p1, sh_p2, sh_p3;
    logic                sh_done;
    logic [COLOR_W-1:0]  sh_color;
    logic                res_valid, res_ready;
    logic [COLOR_W-1:0]  res_color;
    logic [ID_W-1:0]     res_id;
    logic                res_err, idle;
    modport slave (
        input  in_valid, in_p1, in_p2, in_p3, in_id, sh_done, sh_color, res_ready,
        output in_ready, sh_start, sh_sreset, sh_p1, sh_p2, sh_p3,
               res_valid, res_color, res_id, res_err, idle
    );
    modport master (
        output in_valid, in_p1, in_p2, in_p3, in_id, sh_done, sh_color, res_ready,
        input  in_ready, sh_start, sh_sreset, sh_p1, sh_p2, sh_p3,
               res_valid, res_color, res_id, res_err, idle
    );
endinterface

// File: rtl/tri_fifo.sv
// tri_fifo: synchronous FIFO of triangle entries; pushes while full and pops while empty are ignored.
module tri_fifo import shade_pkg::*; #(
    parameter int  DEPTH = 4,
    parameter type T     = tri_entry_t
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output logic                   full,
    output logic                   empty,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rp];
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/shade_dispatch.sv
// shade_dispatch: buffers triangles and runs the flat shader one triangle at a time.
// Optional watchdog abort of a hung shader is enabled by defining SHADE_WDOG_EN.
module shade_dispatch import shade_pkg::*; #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = DEF_ID_W,
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             areset_n,
    shade_dispatch_if.slave bus
);
    typedef struct packed {
        vec3_t p1, p2, p3;
        logic [ID_W-1:0] id;
    } entry_t;
    entry_t din, head;
    logic [$clog2(DEPTH):0] count;
    logic full, empty, pop, load, fire;
    logic [ID_W-1:0] cur_id;
    disp_state_t state, nxt;
    assign din = '{p1: bus.in_p1, p2: bus.in_p2, p3: bus.in_p3, id: bus.in_id};
    tri_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk(clk), .areset_n(areset_n), .push(bus.in_valid), .pop(pop), .din(din),
        .full(full), .empty(empty), .head(head), .count(count)
    );
    assign bus.in_ready = !full;
    assign bus.sh_start = state == LAUNCH;
    assign bus.idle     = count == '0 && state == IDLE && !bus.res_valid;
`ifdef SHADE_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) wd <= '0;
        else if (state == LAUNCH) wd <= '0;
        else if (state == BUSY) wd <= wd + WD_W'(1);
    end
    assign fire = state == BUSY && !bus.sh_done && wd == WD_W'(TIMEOUT - 1);
`else
    assign fire = 1'b0;
`endif
    always_comb begin
        nxt  = state;
        pop  = 1'b0;
        load = 1'b0;
        unique case (state)
            INIT:   nxt = IDLE;
            IDLE: begin
                pop = !empty && (!bus.res_valid || bus.res_ready);
                nxt = pop ? LAUNCH : IDLE;
            end
            LAUNCH: nxt = ARM;
            // the shader still reports done while leaving idle, so done is only trusted from BUSY on
            ARM:    nxt = BUSY;
            BUSY: begin
                load = bus.sh_done || fire;
                nxt  = load ? IDLE : BUSY;
            end
            default: nxt = INIT;
        endcase
    end
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state         <= INIT;
            bus.sh_sreset <= 1'b0;
            bus.sh_p1     <= '0;
            bus.sh_p2     <= '0;
            bus.sh_p3     <= '0;
            cur_id        <= '0;
            bus.res_valid <= 1'b0;
            bus.res_color <= '0;
            bus.res_id    <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            state         <= nxt;
            bus.sh_sreset <= state == INIT || fire;
            if (pop) begin
                bus.sh_p1 <= head.p1;
                bus.sh_p2 <= head.p2;
                bus.sh_p3 <= head.p3;
                cur_id    <= head.id;
            end
            if (load) begin
                bus.res_valid <= 1'b1;
                bus.res_color <= fire ? '0 : bus.sh_color;
                bus.res_id    <= cur_id;
                bus.res_err   <= fire;
            end else if (bus.res_valid && bus.res_ready) begin
                bus.res_valid <= 1'b0;
                bus.res_color <= '0;
                bus.res_id    <= '0;
                bus.res_err   <= 1'b0;
            end
        end
    end
endmodule
